// File: rtl/ex_mem_pipe_hs.sv
// EX->MEM pipeline stage built as a two-entry skid buffer with valid/ready handshake.
// in_ready comes straight from the skid valid flop, so MEM backpressure never reaches EX combinationally.
module ex_mem_pipe_hs #(
    parameter int XLEN        = 32,
    parameter int RA_W        = 5,
    parameter int CNT_W       = 16,
    parameter bit X0_SUPPRESS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  alu_result_ex,
    input  logic [XLEN-1:0]  rs2_data_ex,
    input  logic [RA_W-1:0]  rd_ex,
    input  logic             mem_write_ex,
    input  logic             mem_read_ex,
    input  logic             wb_reg_file_ex,
    input  logic             memtoreg_ex,
    input  logic [2:0]       mem_load_type_ex,
    input  logic [1:0]       mem_store_type_ex,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_result_mem,
    output logic [XLEN-1:0]  rs2_data_mem,
    output logic [RA_W-1:0]  rd_mem,
    output logic             mem_write_mem,
    output logic             mem_read_mem,
    output logic             wb_reg_file_mem,
    output logic             memtoreg_mem,
    output logic [2:0]       mem_load_type_mem,
    output logic [1:0]       mem_store_type_mem,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic            mw;
        logic            mr;
        logic            wb;
        logic            m2r;
        logic [2:0]      lt;
        logic [1:0]      st;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    entry_t     in_p0;
    entry_t     main_p1;
    entry_t     skid_p1;
    logic       main_vld_p1;
    logic       skid_vld_p1;
    logic       accept;
    logic       consume;

    // Stage p0: capture view of the EX payload, with x0 writes killed at entry
    always_comb begin
        in_p0     = '0;
        in_p0.alu = alu_result_ex;
        in_p0.rs2 = rs2_data_ex;
        in_p0.rd  = rd_ex;
        in_p0.mw  = mem_write_ex;
        in_p0.mr  = mem_read_ex;
        in_p0.wb  = wb_reg_file_ex && !(X0_SUPPRESS && (rd_ex == '0));
        in_p0.m2r = memtoreg_ex;
        in_p0.lt  = mem_load_type_ex;
        in_p0.st  = mem_store_type_ex;
    end

    assign in_ready  = !skid_vld_p1;
    assign out_valid = main_vld_p1;
    assign accept    = in_valid && in_ready;
    assign consume   = main_vld_p1 && out_ready;
    assign occupancy = {1'b0, main_vld_p1} + {1'b0, skid_vld_p1};

    // Stage p1: main/skid storage; skid always holds the younger entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
            main_p1     <= '0;
            main_p1.lt  <= 3'b111;
            main_p1.st  <= 2'b11;
            skid_p1     <= '0;
            skid_p1.lt  <= 3'b111;
            skid_p1.st  <= 2'b11;
        end else if (flush) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (!main_vld_p1 || consume) begin
            if (skid_vld_p1) begin
                main_p1     <= skid_p1;
                main_vld_p1 <= 1'b1;
                skid_vld_p1 <= accept;
                if (accept)
                    skid_p1 <= in_p0;
            end else begin
                main_vld_p1 <= accept;
                skid_vld_p1 <= 1'b0;
                if (accept)
                    main_p1 <= in_p0;
            end
        end else if (accept) begin
            skid_p1     <= in_p0;
            skid_vld_p1 <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (main_vld_p1 && !out_ready)
            stall_cnt <= sat_inc(stall_cnt);
    end

    // Output: payload passes through, side-effecting controls are bubble-safe
    assign alu_result_mem     = main_p1.alu;
    assign rs2_data_mem       = main_p1.rs2;
    assign rd_mem             = main_p1.rd;
    assign mem_write_mem      = main_vld_p1 && main_p1.mw;
    assign mem_read_mem       = main_vld_p1 && main_p1.mr;
    assign wb_reg_file_mem    = main_vld_p1 && main_p1.wb;
    assign memtoreg_mem       = main_vld_p1 && main_p1.m2r;
    assign mem_load_type_mem  = main_vld_p1 ? main_p1.lt : 3'b111;
    assign mem_store_type_mem = main_vld_p1 ? main_p1.st : 2'b11;

endmodule
